mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Data-memory stage of the single-clock MIPS core, directly downstream of the execute stage.
- Consumes the execute-stage ALU result as the effective address and register value 2 as store data.
- Performs word, halfword and byte loads and stores against an internal data RAM.
- Produces the write-back value, flags misaligned accesses, and keeps a sticky fault record plus load/store event counters.

Parameters:
- ADDR_W, 10, log2 of RAM depth in 32-bit words (1024 words).

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- Ins  in  32  current instruction; op = Ins[31:26]
- Result  in  32  execute-stage result (effective address for loads/stores, pass-through value otherwise)
- Rdata2  in  32  store data (rt value)
- Wdata  out  32  write-back value
- AdEL  out  1  load address error, combinational, current cycle
- AdES  out  1  store address error, combinational, current cycle
- Fault  out  1  sticky: a misaligned access has occurred since reset
- BadAddr  out  32  address of the first faulting access since reset
- LdCnt  out  32  completed (non-faulting) load count
- StCnt  out  32  completed (non-faulting) store count

Behaviour:
- Opcodes:
  - LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25.
  - SB 0x28, SH 0x29, SW 0x2B.
  - All other opcodes are non-memory.
- RAM:
  - 2^ADDR_W x 32 bits.
  - Word index = Result[ADDR_W+1:2]; higher address bits are ignored, so addresses alias.
  - Byte order is little-endian: byte lane n = bits [8n+7:8n], selected by Result[1:0].
  - Read is combinational (asynchronous).
  - Write occurs on posedge CLK with per-byte enables.
  - RAM contents are not cleared by RST.
- Alignment:
  - Halfword access requires Result[0]=0.
  - Word access requires Result[1:0]=0.
  - Byte access is always aligned.
- Loads, aligned:
  - LB / LBU: selected byte, sign- / zero-extended.
  - LH / LHU: halfword at lane Result[1] (bits [15:0] or [31:16]), sign- / zero-extended.
  - LW: full word.
  - Result is placed on Wdata the same cycle (zero latency).
- Loads, misaligned: AdEL=1, Wdata=0, LdCnt unchanged.
- Stores, aligned:
  - SB writes Rdata2[7:0] to the selected byte lane.
  - SH writes Rdata2[15:0] to the selected halfword lanes.
  - SW writes all four lanes.
  - Unselected lanes keep their previous value.
  - Wdata = Result.
  - New data is visible to a load in the following cycle.
- Stores, misaligned: AdES=1, no RAM write, StCnt unchanged, Wdata = Result.
- Non-memory opcodes:
  - Wdata = Result.
  - AdEL = AdES = 0.
  - No RAM or counter activity.
- Fault / BadAddr:
  - On posedge CLK with RST=0 and (AdEL|AdES)=1: if Fault=0, set Fault<=1 and BadAddr<=Result.
  - If Fault is already 1, both hold; only the first fault is recorded.
  - Cleared only by RST.
- Counters:
  - LdCnt increments on each clock edge with an aligned load.
  - StCnt increments on each clock edge with an aligned store.
  - Both wrap from 0xFFFFFFFF to 0.
- Reset:
  - While RST=1: Fault=0, BadAddr=0, LdCnt=0, StCnt=0 from the next edge.
  - While RST=1: RAM writes are suppressed, including a store presented in the same cycle as RST.
  - Combinational outputs (Wdata, AdEL, AdES) still follow their inputs during reset.
  - Asserting RST mid-program leaves RAM intact; only registers clear.
- At most one memory operation per cycle, so no conflicting read/write cases arise.

Test Plan:
1. SW 0xDEADBEEF @0x10, next cycle LW @0x10 → Wdata=0xDEADBEEF; StCnt=1, LdCnt=1.
2. SW 0 @0x20; SB 0x11 @0x20, SB 0x22 @0x21, SB 0x33 @0x22, SB 0x44 @0x23; LW @0x20 → 0x44332211. SH 0xABCD @0x22, LW @0x20 → 0xABCD2211.
3. SW 0x8000_0080 @0x30:
   - LB @0x30 → 0xFFFFFF80; LBU @0x30 → 0x00000080.
   - LH @0x32 → 0xFFFF8000; LHU @0x32 → 0x00008000.
4. Misaligned accesses:
   - LH @0x41 → AdEL=1, Wdata=0; next edge Fault=1, BadAddr=0x41.
   - Then SW @0x46 → AdES=1, RAM word 0x44 unchanged, BadAddr stays 0x41.
   - LdCnt and StCnt unchanged.
5. Aliasing: SW 0x12345678 @0x00001000 (ADDR_W=10), LW @0x0 → 0x12345678.
6. Reset and non-memory ops:
   - SW 0x5555AAAA @0x50, then SW 0xFFFFFFFF @0x50 with RST=1 → counters/Fault/BadAddr=0.
   - After RST drops, LW @0x50 → 0x5555AAAA.
   - ADD instruction with Result=0x7 → Wdata=0x7, AdEL=AdES=0.

Source files
------------

// File: rtl/mem_access_stage.sv
// Data-memory stage: byte/halfword/word loads and stores against a little-endian RAM.
// Also raises misalignment flags, keeps a sticky first-fault record and counts load/store events.
module mem_access_stage #(
    parameter int ADDR_W = 10
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Ins,
    input  logic [31:0] Result,
    input  logic [31:0] Rdata2,
    output logic [31:0] Wdata,
    output logic        AdEL,
    output logic        AdES,
    output logic        Fault,
    output logic [31:0] BadAddr,
    output logic [31:0] LdCnt,
    output logic [31:0] StCnt
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    logic [5:0]        op;
    logic [25:0]       unused_ins;
    logic              is_load, is_store, is_byte, is_half, is_word, is_signed;
    logic              misaligned;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        lane;
    logic [3:0]        wr_en_lane;
    logic [31:0]       wr_data;
    logic [31:0]       rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_val;

    logic        fault_q,    fault_d;
    logic [31:0] bad_addr_q, bad_addr_d;
    logic [31:0] ld_cnt_q,   ld_cnt_d;
    logic [31:0] st_cnt_q,   st_cnt_d;

    assign op         = Ins[31:26];
    assign unused_ins = Ins[25:0];
    assign word_idx   = Result[ADDR_W+1:2];
    assign lane       = Result[1:0];

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_byte   = 1'b0;
        is_half   = 1'b0;
        is_word   = 1'b0;
        is_signed = 1'b0;
        case (op)
            OP_LB:  begin is_load  = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
            OP_LBU: begin is_load  = 1'b1; is_byte = 1'b1; end
            OP_LH:  begin is_load  = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
            OP_LHU: begin is_load  = 1'b1; is_half = 1'b1; end
            OP_LW:  begin is_load  = 1'b1; is_word = 1'b1; end
            OP_SB:  begin is_store = 1'b1; is_byte = 1'b1; end
            OP_SH:  begin is_store = 1'b1; is_half = 1'b1; end
            OP_SW:  begin is_store = 1'b1; is_word = 1'b1; end
            default: ;
        endcase
    end

    assign misaligned = (is_half & Result[0]) | (is_word & (|Result[1:0]));
    assign AdEL       = is_load  & misaligned;
    assign AdES       = is_store & misaligned;

    // Store lanes are gated by RST so a store coinciding with reset never lands.
    always_comb begin
        wr_en_lane = 4'b0000;
        if (is_store && !misaligned && !RST) begin
            if (is_byte)
                wr_en_lane[lane] = 1'b1;
            else if (is_half)
                wr_en_lane = Result[1] ? 4'b1100 : 4'b0011;
            else
                wr_en_lane = 4'b1111;
        end
    end

    assign wr_data = is_byte ? {4{Rdata2[7:0]}} :
                     is_half ? {2{Rdata2[15:0]}} : Rdata2;

    // One byte-wide array per lane gives independent byte write enables.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            always_ff @(posedge CLK) begin
                if (wr_en_lane[gi])
                    lane_mem[word_idx] <= wr_data[8*gi +: 8];
            end
            assign rd_word[8*gi +: 8] = lane_mem[word_idx];
        end
    endgenerate

    assign rd_byte = rd_word[8*lane +: 8];
    assign rd_half = Result[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_val = rd_word;
        if (is_byte)
            load_val = {{24{is_signed & rd_byte[7]}}, rd_byte};
        else if (is_half)
            load_val = {{16{is_signed & rd_half[15]}}, rd_half};
    end

    assign Wdata = is_load ? (misaligned ? 32'h0 : load_val) : Result;

    always_comb begin
        fault_d    = fault_q;
        bad_addr_d = bad_addr_q;
        ld_cnt_d   = ld_cnt_q;
        st_cnt_d   = st_cnt_q;
        if ((AdEL || AdES) && !fault_q) begin
            fault_d    = 1'b1;
            bad_addr_d = Result;
        end
        if (is_load && !misaligned)
            ld_cnt_d = ld_cnt_q + 32'd1;
        if (is_store && !misaligned)
            st_cnt_d = st_cnt_q + 32'd1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fault_q    <= 1'b0;
            bad_addr_q <= 32'h0;
            ld_cnt_q   <= 32'h0;
            st_cnt_q   <= 32'h0;
        end else begin
            fault_q    <= fault_d;
            bad_addr_q <= bad_addr_d;
            ld_cnt_q   <= ld_cnt_d;
            st_cnt_q   <= st_cnt_d;
        end
    end

    assign Fault   = fault_q;
    assign BadAddr = bad_addr_q;
    assign LdCnt   = ld_cnt_q;
    assign StCnt   = st_cnt_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus random traffic against a byte-level memory model.
module tb_mem_access_stage;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
    localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B, ADD = 6'h00, ORI = 6'h0D, BEQ = 6'h04;

    logic        CLK, RST;
    logic [31:0] Ins, Result, Rdata2;
    logic [31:0] Wdata, BadAddr, LdCnt, StCnt;
    logic        AdEL, AdES, Fault;

    mem_access_stage #(.ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .RST(RST), .Ins(Ins), .Result(Result), .Rdata2(Rdata2),
        .Wdata(Wdata), .AdEL(AdEL), .AdES(AdES), .Fault(Fault),
        .BadAddr(BadAddr), .LdCnt(LdCnt), .StCnt(StCnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks = 0;
    int errors = 0;

    // Reference state: memory as a plain array of bytes indexed by byte address modulo RAM size.
    byte unsigned m_bytes [DEPTH*4];
    logic        m_fault;
    logic [31:0] m_bad, m_ld, m_st;
    logic [31:0] last_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic int op_size(input logic [5:0] op);
        case (op)
            LB, LBU, SB: return 1;
            LH, LHU, SH: return 2;
            LW, SW:      return 4;
            default:     return 0;
        endcase
    endfunction

    function automatic bit is_ld(input logic [5:0] op);
        return op == LB || op == LBU || op == LH || op == LHU || op == LW;
    endfunction

    function automatic bit is_st(input logic [5:0] op);
        return op == SB || op == SH || op == SW;
    endfunction

    // One cycle: present inputs, check combinational outputs, clock, check registered outputs.
    task automatic step(input logic [5:0] op, input logic [31:0] res, input logic [31:0] rd2,
                        input logic rst);
        int          sz;
        bit          ld, st, mis;
        int unsigned base;
        logic [31:0] val, exp_w;
        sz   = op_size(op);
        ld   = is_ld(op);
        st   = is_st(op);
        mis  = (sz != 0) && ((res % sz) != 0);
        base = res % (DEPTH*4);
        Ins = {op, 26'($urandom)}; Result = res; Rdata2 = rd2; RST = rst;
        #1;
        exp_w = res;
        if (ld) begin
            if (mis) exp_w = 0;
            else begin
                val = 0;
                for (int k = 0; k < sz; k++) val = val | (32'(m_bytes[base + k]) << (8*k));
                if ((op == LB) && val >= 32'h80)   val = val - 32'h100;
                if ((op == LH) && val >= 32'h8000) val = val - 32'h10000;
                exp_w = val;
            end
        end
        chk($sformatf("Wdata op=%02h a=%08h", op, res), Wdata, exp_w);
        chk("AdEL", 32'(AdEL), 32'(ld && mis));
        chk("AdES", 32'(AdES), 32'(st && mis));
        last_wdata = Wdata;
        $display("t=%0t op=%02h addr=%08h data=%08h rst=%0b -> Wdata=%08h AdEL=%0b AdES=%0b",
                 $time, op, res, rd2, rst, Wdata, AdEL, AdES);
        @(posedge CLK);
        if (rst) begin
            m_fault = 0; m_bad = 0; m_ld = 0; m_st = 0;
        end else begin
            if ((ld || st) && mis && !m_fault) begin m_fault = 1; m_bad = res; end
            if (ld && !mis) m_ld++;
            if (st && !mis) begin
                for (int k = 0; k < sz; k++) m_bytes[base + k] = byte'(rd2 >> (8*k));
                m_st++;
            end
        end
        #1;
        chk("Fault",   32'(Fault), 32'(m_fault));
        chk("BadAddr", BadAddr, m_bad);
        chk("LdCnt",   LdCnt,   m_ld);
        chk("StCnt",   StCnt,   m_st);
    endtask

    initial begin
        logic [5:0]  ops [11];
        logic [5:0]  op;
        logic [31:0] a;
        ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW, ADD, ORI, BEQ};
        m_fault = 0; m_bad = 0; m_ld = 0; m_st = 0;
        Ins = 0; Result = 0; Rdata2 = 0; RST = 1;

        step(ADD, 32'h0, 32'h0, 1'b1);
        step(ADD, 32'h0, 32'h0, 1'b1);
        chk("reset Fault", 32'(Fault), 32'h0);
        chk("reset LdCnt", LdCnt, 32'h0);

        // Fill the whole RAM so every later load has defined contents.
        for (int i = 0; i < DEPTH; i++) step(SW, 32'(i*4), $urandom, 1'b0);
        step(ADD, 32'h0, 32'h0, 1'b1);

        // Store then load back.
        step(SW, 32'h10, 32'hDEADBEEF, 1'b0);
        step(LW, 32'h10, 32'h0, 1'b0);
        chk("tp1 LW", last_wdata, 32'hDEADBEEF);
        chk("tp1 StCnt", StCnt, 32'd1);
        chk("tp1 LdCnt", LdCnt, 32'd1);

        // Byte and halfword stores merge into a word.
        step(SW, 32'h20, 32'h0, 1'b0);
        step(SB, 32'h20, 32'hFFFFFF11, 1'b0);
        step(SB, 32'h21, 32'h00000022, 1'b0);
        step(SB, 32'h22, 32'h12345633, 1'b0);
        step(SB, 32'h23, 32'h00000044, 1'b0);
        step(LW, 32'h20, 32'h0, 1'b0);
        chk("tp2 bytes", last_wdata, 32'h44332211);
        step(SH, 32'h22, 32'h9999ABCD, 1'b0);
        step(LW, 32'h20, 32'h0, 1'b0);
        chk("tp2 half", last_wdata, 32'hABCD2211);

        // Sign and zero extension.
        step(SW, 32'h30, 32'h80000080, 1'b0);
        step(LB,  32'h30, 0, 1'b0); chk("tp3 LB",  last_wdata, 32'hFFFFFF80);
        step(LBU, 32'h30, 0, 1'b0); chk("tp3 LBU", last_wdata, 32'h00000080);
        step(LH,  32'h32, 0, 1'b0); chk("tp3 LH",  last_wdata, 32'hFFFF8000);
        step(LHU, 32'h32, 0, 1'b0); chk("tp3 LHU", last_wdata, 32'h00008000);

        // Misalignment and sticky first fault.
        step(SW, 32'h44, 32'hCAFEF00D, 1'b0);
        step(LH, 32'h41, 0, 1'b0);
        chk("tp4 LH mis Wdata", last_wdata, 32'h0);
        chk("tp4 BadAddr", BadAddr, 32'h41);
        step(SW, 32'h46, 32'h11111111, 1'b0);
        chk("tp4 BadAddr hold", BadAddr, 32'h41);
        step(LW, 32'h44, 0, 1'b0);
        chk("tp4 word intact", last_wdata, 32'hCAFEF00D);

        // Aliasing beyond the RAM size.
        step(SW, 32'h00001000, 32'h12345678, 1'b0);
        step(LW, 32'h0, 0, 1'b0);
        chk("tp5 alias", last_wdata, 32'h12345678);

        // Reset suppresses a simultaneous store and leaves RAM intact.
        step(SW, 32'h50, 32'h5555AAAA, 1'b0);
        step(SW, 32'h50, 32'hFFFFFFFF, 1'b1);
        chk("tp6 Fault", 32'(Fault), 32'h0);
        chk("tp6 StCnt", StCnt, 32'h0);
        step(LW, 32'h50, 0, 1'b0);
        chk("tp6 LW", last_wdata, 32'h5555AAAA);
        step(ADD, 32'h7, 32'h0, 1'b0);
        chk("tp6 ADD", last_wdata, 32'h7);

        // Random traffic concentrated on a small window so loads hit recent stores.
        for (int i = 0; i < 600; i++) begin
            op = ops[$urandom_range(10, 0)];
            a  = 32'($urandom_range(63, 0)) | (($urandom_range(3, 0) == 0) ? ($urandom << 12) : 32'h0);
            step(op, a, $urandom, ($urandom_range(49, 0) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
